// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Optional checksum trailer is enabled by defining IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

  localparam int ADDR_W_DEFAULT = 6;
  localparam int LANES          = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DATA  = 2'd2,
    ST_CHECK = 2'd3
  } state_e;

  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/imem_loader_word_packer.sv
// Collects bytes MSB-first into a 32-bit word; word_ready_o marks the 4th byte's strobe
// and word_o is valid in that same cycle.
module imem_loader_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic [31:0] word_o,
  output logic        word_ready_o
);

  logic [1:0]  lane_q, lane_d;
  logic [23:0] shift_q, shift_d;
  logic        accept_s;

  assign accept_s     = en_i & rx_valid_i;
  assign word_ready_o = accept_s & (lane_q == 2'(LANES - 1));
  assign word_o       = {shift_q, rx_data_i};

  always_comb begin
    lane_d  = lane_q;
    shift_d = shift_q;
    if (clr_i) begin
      lane_d  = 2'd0;
      shift_d = 24'd0;
    end else if (accept_s) begin
      lane_d  = lane_q + 2'd1;
      shift_d = {shift_q[15:0], rx_data_i};
    end else begin
      lane_d  = lane_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lane_q  <= 2'd0;
      shift_q <= 24'd0;
    end else begin
      lane_q  <= lane_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction memory: count byte, N big-endian words,
// optional XOR trailer (IMEM_LOADER_CHECKSUM_EN). All outputs are registered.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        we_o,
  output logic [31:0] wa_o,
  output logic [31:0] wd_o,
  output logic        busy_o,
  output logic        cpu_hold_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int DEPTH = depth_of(ADDR_W);
  localparam int CNT_W = ADDR_W + 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic               we_q, we_d;
  logic [31:0]        wa_q, wa_d;
  logic [31:0]        wd_q, wd_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]         csum_q, csum_d;
`endif

  logic               pk_clr_s, pk_en_s, pk_ready_s;
  logic [31:0]        pk_word_s;
  logic [CNT_W-1:0]   idx_inc_s;

  imem_loader_word_packer u_packer (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clr_i        (pk_clr_s),
    .en_i         (pk_en_s),
    .rx_data_i    (rx_data_i),
    .rx_valid_i   (rx_valid_i),
    .word_o       (pk_word_s),
    .word_ready_o (pk_ready_s)
  );

  assign idx_inc_s = idx_q + CNT_W'(1);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    idx_d    = idx_q;
    we_d     = 1'b0;
    wa_d     = wa_q;
    wd_d     = wd_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    pk_clr_s = 1'b0;
    pk_en_s  = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d   = csum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (load_i) begin
          state_d  = ST_COUNT;
          busy_d   = 1'b1;
          err_d    = 1'b0;
          idx_d    = '0;
          pk_clr_s = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d   = 8'd0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COUNT: begin
        if (rx_valid_i) begin
          if ({1'b0, rx_data_i} > 9'(DEPTH)) begin
            err_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            count_d = (rx_data_i == 8'd0) ? CNT_W'(DEPTH) : CNT_W'(rx_data_i);
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_COUNT;
        end
      end
      ST_DATA: begin
        pk_en_s = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (rx_valid_i) begin
          csum_d = csum_step(csum_q, rx_data_i);
        end else begin
          csum_d = csum_q;
        end
`endif
        if (pk_ready_s) begin
          we_d  = 1'b1;
          wd_d  = pk_word_s;
          wa_d  = {{(30 - ADDR_W){1'b0}}, idx_q[ADDR_W-1:0], 2'b00};
          idx_d = idx_inc_s;
          if (idx_inc_s == count_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = ST_CHECK;
`else
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
`endif
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (rx_valid_i) begin
          if (rx_data_i == csum_q) begin
            done_d = 1'b1;
          end else begin
            err_d  = 1'b1;
          end
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_CHECK;
        end
      end
`endif
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      wa_q    <= 32'd0;
      wd_q    <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign we_o       = we_q;
  assign wa_o       = wa_q;
  assign wd_o       = wd_q;
  assign busy_o     = busy_q;
  assign cpu_hold_o = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; follows IMEM_LOADER_CHECKSUM_EN when defined.
module tb_imem_loader;

  logic        clk;
  logic        rst;
  logic        load;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        we_o, busy_o, cpu_hold_o, done_o, err_o;
  logic [31:0] wa_o, wd_o;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] wr_a[$];
  logic [31:0] wr_d[$];
  int          done_cnt  = 0;
  int          b2b_cnt   = 0;
  logic        done_we   = 1'b0;
  logic        prev_we   = 1'b0;

  imem_loader dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (load),
    .rx_data_i  (rx_data),
    .rx_valid_i (rx_valid),
    .we_o       (we_o),
    .wa_o       (wa_o),
    .wd_o       (wd_o),
    .busy_o     (busy_o),
    .cpu_hold_o (cpu_hold_o),
    .done_o     (done_o),
    .err_o      (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst) begin
      prev_we <= 1'b0;
    end else begin
      if (we_o) begin
        wr_a.push_back(wa_o);
        wr_d.push_back(wd_o);
        if (prev_we) b2b_cnt <= b2b_cnt + 1;
      end
      if (done_o) begin
        done_cnt <= done_cnt + 1;
        done_we  <= we_o;
      end
      prev_we <= we_o;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load();
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic clr_sb();
    wr_a.delete();
    wr_d.delete();
    done_cnt = 0;
    b2b_cnt  = 0;
    done_we  = 1'b0;
  endtask

  // count byte first, data bytes after; trailer appended when the checksum build is on
  task automatic send_frame(input logic [7:0] fr[$], input int gap);
    logic [7:0] cs;
    cs = 8'd0;
    for (int i = 0; i < fr.size(); i++) begin
      if (i > 0) cs = cs ^ fr[i];
      send(fr[i], gap);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(cs, gap);
`endif
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (busy_o && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_timeout"}, 64'(busy_o), 64'd0);
    repeat (3) tick();
  endtask

  task automatic check_t1(input string tag);
    check({tag, "_nwr"}, 64'(wr_a.size()), 64'd2);
    if (wr_a.size() == 2) begin
      check({tag, "_wa0"}, 64'(wr_a[0]), 64'h00);
      check({tag, "_wd0"}, 64'(wr_d[0]), 64'h12345678);
      check({tag, "_wa1"}, 64'(wr_a[1]), 64'h04);
      check({tag, "_wd1"}, 64'(wr_d[1]), 64'h9ABCDEF0);
    end
    check({tag, "_done"}, 64'(done_cnt), 64'd1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check({tag, "_done_we"}, 64'(done_we), 64'd0);
`else
    check({tag, "_done_we"}, 64'(done_we), 64'd1);
`endif
    check({tag, "_b2b"}, 64'(b2b_cnt), 64'd0);
    check({tag, "_busy"}, {63'd0, busy_o}, 64'd0);
    check({tag, "_err"}, {63'd0, err_o}, 64'd0);
  endtask

  logic [7:0] t1[$] = '{8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
  int         gaps[9] = '{0, 20, 3, 1, 7, 0, 12, 5, 2};

  initial begin
    logic [7:0]  fr[$];
    logic [31:0] exp_d;
    int          bad;
    logic [7:0]  cs;

    rst = 1'b1; load = 1'b0; rx_data = 8'd0; rx_valid = 1'b0;
    repeat (3) tick();
    check("rst_ctrl", {59'd0, we_o, busy_o, cpu_hold_o, done_o, err_o}, 64'd0);
    check("rst_wa", 64'(wa_o), 64'd0);
    check("rst_wd", 64'(wd_o), 64'd0);
    rst = 1'b0;
    tick();

    // test 1: two words
    clr_sb();
    pulse_load();
    check("t1_busy", {62'd0, busy_o, cpu_hold_o}, 64'd3);
    send(8'h55, 0); // count byte
    fr = t1;
    fr.delete(0);
    cs = 8'd0;
    foreach (fr[i]) begin
      cs = cs ^ fr[i];
      send(fr[i], 0);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(cs, 0);
`endif
    wait_idle("t1", 50);
    // the 0x55 count is illegal only if > 64, so this run is 85 > 64 -> err
    check("t1pre_err", {63'd0, err_o}, 64'd1);
    check("t1pre_nwr", 64'(wr_a.size()), 64'd0);

    clr_sb();
    pulse_load();
    check("t1_errclr", {63'd0, err_o}, 64'd0);
    send_frame(t1, 0);
`ifndef IMEM_LOADER_CHECKSUM_EN
    check("t1_last_we_done", {62'd0, we_o, done_o}, 64'd3);
`else
    check("t1_last_done", {63'd0, done_o}, 64'd1);
`endif
    wait_idle("t1", 50);
    check_t1("t1");

    // test 2: count 65 rejected, rx in IDLE ignored, next load clears err
    clr_sb();
    pulse_load();
    send(8'h41, 0);
    send(8'h11, 0);
    send(8'h22, 0);
    send(8'h33, 0);
    send(8'h44, 0);
    repeat (3) tick();
    check("t2_err", {63'd0, err_o}, 64'd1);
    check("t2_busy", {62'd0, busy_o, cpu_hold_o}, 64'd0);
    check("t2_nwr", 64'(wr_a.size()), 64'd0);
    pulse_load();
    check("t2_errclr", {63'd0, err_o}, 64'd0);
    fr = '{8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
    send_frame(fr, 1);
    wait_idle("t2", 50);
    check("t2_wd", (wr_d.size() == 1) ? 64'(wr_d[0]) : 64'hDEAD, 64'hCAFEBABE);
    check("t2_done", 64'(done_cnt), 64'd1);

    // test 3: count 0 -> 64 words
    clr_sb();
    pulse_load();
    fr = '{8'h00};
    for (int i = 0; i < 256; i++) fr.push_back(8'(i));
    send_frame(fr, 0);
    wait_idle("t3", 50);
    check("t3_nwr", 64'(wr_a.size()), 64'd64);
    bad = 0;
    for (int k = 0; k < 64 && k < wr_a.size(); k++) begin
      exp_d = {8'(4 * k), 8'(4 * k + 1), 8'(4 * k + 2), 8'(4 * k + 3)};
      if (wr_a[k] !== 32'(4 * k) || wr_d[k] !== exp_d) bad++;
    end
    check("t3_words", 64'(bad), 64'd0);
    check("t3_done", 64'(done_cnt), 64'd1);
    check("t3_b2b", 64'(b2b_cnt), 64'd0);
    send(8'h77, 0);
    repeat (5) send(8'h66, 0);
    repeat (3) tick();
    check("t3_post_nwr", 64'(wr_a.size()), 64'd64);

    // test 4: reset mid-load, then restart at address 0
    clr_sb();
    pulse_load();
    send(8'h02, 0);
    for (int i = 0; i < 6; i++) send(8'(8'h10 + i), 0);
    check("t4_prewr", 64'(wr_a.size()), 64'd1);
    rst = 1'b1;
    #1;
    check("t4_rst_ctrl", {59'd0, we_o, busy_o, cpu_hold_o, done_o, err_o}, 64'd0);
    check("t4_rst_wawd", {wa_o, wd_o}, 64'd0);
    tick();
    rst = 1'b0;
    tick();
    clr_sb();
    pulse_load();
    fr = '{8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_frame(fr, 0);
    wait_idle("t4", 50);
    check("t4_wa", (wr_a.size() == 1) ? 64'(wr_a[0]) : 64'hDEAD, 64'h0);
    check("t4_wd", (wr_d.size() == 1) ? 64'(wr_d[0]) : 64'hDEAD, 64'hAABBCCDD);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // test 5: checksum match and mismatch
    clr_sb();
    pulse_load();
    fr = '{8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    foreach (fr[i]) send(fr[i], 0);
    check("t5_busy_check", {63'd0, busy_o}, 64'd1);
    send(8'h44, 0);
    check("t5_done_now", {63'd0, done_o}, 64'd1);
    wait_idle("t5", 50);
    check("t5_wd", (wr_d.size() == 1) ? 64'(wr_d[0]) : 64'hDEAD, 64'h11223344);
    check("t5_done", 64'(done_cnt), 64'd1);
    check("t5_err", {63'd0, err_o}, 64'd0);
    clr_sb();
    pulse_load();
    foreach (fr[i]) send(fr[i], 0);
    send(8'h45, 0);
    wait_idle("t5b", 50);
    check("t5b_err", {63'd0, err_o}, 64'd1);
    check("t5b_done", 64'(done_cnt), 64'd0);
    check("t5b_nwr", 64'(wr_a.size()), 64'd1);
`endif

    // test 6: load pulse mid-DATA and uneven rx gaps
    clr_sb();
    pulse_load();
    cs = 8'd0;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) cs = cs ^ t1[i];
      send(t1[i], gaps[i]);
      if (i == 3) pulse_load();
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(cs, 4);
`endif
    wait_idle("t6", 50);
    check_t1("t6");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
